// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-port bundle between a bus-matrix output stage (master side)
// and the ahb_sram_slave responder (slave side).
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
    output HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
    input  HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: one-entry write buffer with read-after-write merge and WAIT_STATES wait cycles.
// Optional AHB_SRAM_ALIGN_CHK_EN: illegal size/alignment gets a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int AW          = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                HCLK,
  input  logic                HRESET,
  ahb_sram_slave_if.slave     ahb,
  output logic                ram_cs,
  output logic                ram_we,
  output logic [AW-1:0]       ram_addr,
  output logic [3:0]          ram_wben,
  output logic [31:0]         ram_wdata,
  input  logic [31:0]         ram_rdata
);

`ifdef AHB_SRAM_ALIGN_CHK_EN
  typedef enum logic [1:0] {ST_DONE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic [1:0] {ST_DONE, ST_WAIT} state_t;
`endif

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t          state;
  logic [3:0]      wait_cnt;
  logic            hready_q;
`ifdef AHB_SRAM_ALIGN_CHK_EN
  logic            hresp_q;
`endif

  logic            accept;
  logic            req_illegal;
  logic            legal_accept;
  logic            read_issue;
  logic [3:0]      req_mask;

  logic            dp_read;
  logic            dp_write;
  logic [AW-1:0]   dp_addr;
  logic [3:0]      dp_mask;

  logic            buf_valid;
  logic [AW-1:0]   buf_addr;
  logic [3:0]      buf_mask;
  logic [31:0]     buf_data;
  logic            buf_load;
  logic            commit;
  logic            buf_hit;
  logic [31:0]     merged;

  logic            unused_ok;
  assign unused_ok = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK, ahb.HTRANS[0],
                       ahb.HADDR[31:AW+2], ahb.HADDR[0]};

  // Gating with HRESET keeps the SRAM strobes at their reset values while reset is held.
  assign accept       = ~HRESET & ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign legal_accept = accept & ~req_illegal;
  assign read_issue   = legal_accept & ~ahb.HWRITE;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    req_mask    = 4'b0000;
    req_illegal = 1'b0;
`ifdef AHB_SRAM_ALIGN_CHK_EN
    case (ahb.HSIZE)
      3'd0: req_mask = 4'b0001 << ahb.HADDR[1:0];
      3'd1: begin
        req_mask    = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
        req_illegal = ahb.HADDR[0];
      end
      3'd2: begin
        req_mask    = 4'b1111;
        req_illegal = |ahb.HADDR[1:0];
      end
      default: req_illegal = 1'b1;
    endcase
`else
    case (ahb.HSIZE)
      3'd0:    req_mask = 4'b0001 << ahb.HADDR[1:0];
      3'd1:    req_mask = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
      default: req_mask = 4'b1111;
    endcase
`endif
  end

  // Data-phase FSM; HREADYOUT/HRESP are registered alongside the state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_DONE;
      wait_cnt <= 4'd0;
      hready_q <= 1'b1;
`ifdef AHB_SRAM_ALIGN_CHK_EN
      hresp_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt <= 4'd1) begin
            state    <= ST_DONE;
            hready_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
`ifdef AHB_SRAM_ALIGN_CHK_EN
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
`endif
        default: begin
          // ST_DONE, and ST_ERR2 which takes a new transfer exactly like ST_DONE.
          state    <= ST_DONE;
          hready_q <= 1'b1;
`ifdef AHB_SRAM_ALIGN_CHK_EN
          hresp_q  <= 1'b0;
          if (accept && req_illegal) begin
            state    <= ST_ERR1;
            hready_q <= 1'b0;
            hresp_q  <= 1'b1;
          end else
`endif
          if (accept && WS != 4'd0) begin
            state    <= ST_WAIT;
            wait_cnt <= WS;
            hready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Address-phase attributes carried into the data phase; they advance only when the bus does.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_read  <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_mask  <= 4'b0000;
    end else if (ahb.HREADY) begin
      dp_read  <= read_issue;
      dp_write <= legal_accept & ahb.HWRITE;
      dp_addr  <= ahb.HADDR[AW+1:2];
      dp_mask  <= req_mask;
    end
  end

  // Write data is captured on the last data-phase cycle and drained when the SRAM port is free.
  // A read waiting on wait states must not see its ram_rdata disturbed, so commits hold off.
  assign buf_load = dp_write & hready_q;
  assign commit   = buf_valid & ~read_issue & ~(dp_read & ~hready_q);

  // NOTE: the buffer payload is reset as well, so the SRAM port drives defined values after reset.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_mask  <= 4'b0000;
      buf_data  <= 32'd0;
    end else if (buf_load) begin
      buf_valid <= 1'b1;
      buf_addr  <= dp_addr;
      buf_mask  <= dp_mask;
      buf_data  <= ahb.HWDATA;
    end else if (commit) begin
      buf_valid <= 1'b0;
    end
  end

  // Read issue wins the single SRAM port; otherwise the buffer drains.
  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wben  = 4'b0000;
    ram_wdata = 32'd0;
    if (read_issue) begin
      ram_cs   = 1'b1;
      ram_addr = ahb.HADDR[AW+1:2];
    end else if (commit) begin
      ram_cs    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = buf_addr;
      ram_wben  = buf_mask;
      ram_wdata = buf_data;
    end
  end

  assign buf_hit = buf_valid & (buf_addr == dp_addr);

  always_comb begin
    merged = ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (buf_hit && buf_mask[i]) merged[8*i +: 8] = buf_data[8*i +: 8];
    end
  end

  assign ahb.HRDATA    = dp_read ? merged : 32'd0;
  assign ahb.HREADYOUT = hready_q;
`ifdef AHB_SRAM_ALIGN_CHK_EN
  assign ahb.HRESP     = hresp_q;
`else
  assign ahb.HRESP     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances (WAIT_STATES 0, 2, 3) share one master driver,
// each backed by a behavioural single-port SRAM.
module tb_ahb_sram_slave;
  localparam int AW   = 8;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  logic          pl_en;
  int            pl_dut;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;

  logic          o_ready [NDUT];
  logic          o_resp  [NDUT];
  logic [31:0]   o_rdata [NDUT];
  logic          o_cs    [NDUT];
  logic          o_we    [NDUT];
  logic [AW-1:0] o_addr  [NDUT];
  logic [3:0]    o_wben  [NDUT];
  logic [31:0]   o_wdata [NDUT];

  int vectors     = 0;
  int miscompares = 0;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int WS = (k == 0) ? 0 : ((k == 1) ? 2 : 3);

    ahb_sram_slave_if bus ();
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_wben;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    bit   [31:0]   mem [0:(1<<AW)-1];
    logic [31:0]   nw;

    assign bus.HSEL      = hsel && (sel == k);
    assign bus.HADDR     = haddr;
    assign bus.HTRANS    = htrans;
    assign bus.HWRITE    = hwrite;
    assign bus.HSIZE     = hsize;
    assign bus.HBURST    = 3'd0;
    assign bus.HPROT     = 4'd0;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HREADY    = bus.HREADYOUT;
    assign bus.HWDATA    = hwdata;

    ahb_sram_slave #(.AW(AW), .WAIT_STATES(WS)) dut (
      .HCLK      (clk),
      .HRESET    (rst),
      .ahb       (bus),
      .ram_cs    (ram_cs),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wben  (ram_wben),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
    );

    always @(posedge clk) begin
      if (pl_en && pl_dut == k) begin
        mem[pl_addr] <= pl_data;
      end else if (ram_cs) begin
        if (ram_we) begin
          nw = mem[ram_addr];
          for (int b = 0; b < 4; b++) if (ram_wben[b]) nw[8*b +: 8] = ram_wdata[8*b +: 8];
          mem[ram_addr] <= nw;
        end else begin
          ram_rdata <= mem[ram_addr];
        end
      end
    end

    assign o_ready[k] = bus.HREADYOUT;
    assign o_resp[k]  = bus.HRESP;
    assign o_rdata[k] = bus.HRDATA;
    assign o_cs[k]    = ram_cs;
    assign o_we[k]    = ram_we;
    assign o_addr[k]  = ram_addr;
    assign o_wben[k]  = ram_wben;
    assign o_wdata[k] = ram_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = 32'd0;
    hsize  = 3'd2;
  endtask

  task automatic drive_addr(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic preload(input int k, input int word, input logic [31:0] d);
    pl_dut  = k;
    pl_addr = AW'(word);
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  // Called right after a sample; counts HREADYOUT-low cycles until ready, bounded at 20.
  task automatic wait_ready(output int lows);
    lows = 0;
    while (o_ready[sel] !== 1'b1 && lows < 20) begin
      lows++;
      tick();
      sample();
    end
  endtask

  task automatic test_reset();
    sel = 0;
    sample();
    for (int k = 0; k < NDUT; k++) begin
      vectors++; if (o_ready[k] !== 1'b1) begin miscompares++; $display("FAIL rst_hreadyout[%0d]: got %b want 1", k, o_ready[k]); end
      vectors++; if (o_resp[k] !== 1'b0) begin miscompares++; $display("FAIL rst_hresp[%0d]: got %b want 0", k, o_resp[k]); end
      vectors++; if (o_rdata[k] !== 32'd0) begin miscompares++; $display("FAIL rst_hrdata[%0d]: got %h want 0", k, o_rdata[k]); end
      vectors++; if ({o_cs[k], o_we[k], o_addr[k], o_wben[k], o_wdata[k]} !== '0) begin
        miscompares++;
        $display("FAIL rst_ram_port[%0d]: got cs=%b we=%b addr=%h wben=%h wdata=%h want all 0",
                 k, o_cs[k], o_we[k], o_addr[k], o_wben[k], o_wdata[k]);
      end
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_write_read_merge();
    sel = 0;
    tick(); drive_addr(1'b1, 32'h40, 3'd2); sample();
    vectors++; if (o_cs[sel] !== 1'b0) begin miscompares++; $display("FAIL wr_addr_no_access: got cs=%b want 0", o_cs[sel]); end
    tick(); hwdata = 32'h12345678; drive_addr(1'b0, 32'h40, 3'd2); sample();
    vectors++; if ({o_cs[sel], o_we[sel]} !== 2'b10) begin miscompares++; $display("FAIL raw_read_issue: got cs/we=%b want 10", {o_cs[sel], o_we[sel]}); end
    vectors++; if (o_addr[sel] !== 8'h10) begin miscompares++; $display("FAIL raw_read_addr: got %h want 10", o_addr[sel]); end
    tick(); drive_idle(); sample();
    vectors++; if (o_rdata[sel] !== 32'h12345678) begin miscompares++; $display("FAIL raw_merge_word: got %h want 12345678", o_rdata[sel]); end
    vectors++; if ({o_we[sel], o_addr[sel], o_wdata[sel]} !== {1'b1, 8'h10, 32'h12345678}) begin
      miscompares++; $display("FAIL raw_commit: got we=%b addr=%h wdata=%h want 1/10/12345678", o_we[sel], o_addr[sel], o_wdata[sel]);
    end
    tick(); sample();
    vectors++; if (o_rdata[sel] !== 32'd0) begin miscompares++; $display("FAIL hrdata_idle_zero: got %h want 0", o_rdata[sel]); end
  endtask

  task automatic test_byte_merge();
    sel = 0;
    preload(0, 16, 32'h11223344);
    tick(); drive_addr(1'b1, 32'h43, 3'd0); sample();
    tick(); hwdata = 32'hAA000000; drive_addr(1'b0, 32'h40, 3'd2); sample();
    vectors++; if ({o_cs[sel], o_we[sel]} !== 2'b10) begin miscompares++; $display("FAIL byte_read_issue: got cs/we=%b want 10", {o_cs[sel], o_we[sel]}); end
    tick(); drive_idle(); sample();
    vectors++; if (o_rdata[sel] !== 32'hAA223344) begin miscompares++; $display("FAIL byte_merge: got %h want aa223344", o_rdata[sel]); end
    vectors++; if ({o_we[sel], o_wben[sel]} !== 5'b1_1000) begin miscompares++; $display("FAIL byte_commit_wben: got we=%b wben=%b want 1/1000", o_we[sel], o_wben[sel]); end
  endtask

  task automatic test_back_to_back();
    int lows;
    sel = 1;
    tick(); drive_addr(1'b1, 32'h0, 3'd2); sample();
    vectors++; if (o_ready[sel] !== 1'b1) begin miscompares++; $display("FAIL b2b_addr_ready: got %b want 1", o_ready[sel]); end
    tick(); hwdata = 32'hA0A0A0A0; drive_addr(1'b1, 32'h4, 3'd2); sample();
    wait_ready(lows);
    vectors++; if (lows !== 2) begin miscompares++; $display("FAIL b2b_wait_first: got %0d low cycles want 2", lows); end
    tick(); hwdata = 32'hB0B0B0B0; drive_idle(); sample();
    vectors++; if ({o_cs[sel], o_we[sel], o_addr[sel], o_wben[sel], o_wdata[sel]} !== {2'b11, 8'h00, 4'hF, 32'hA0A0A0A0}) begin
      miscompares++; $display("FAIL b2b_commit_first: got cs=%b we=%b addr=%h wben=%h wdata=%h want 1/1/00/f/a0a0a0a0",
                              o_cs[sel], o_we[sel], o_addr[sel], o_wben[sel], o_wdata[sel]);
    end
    wait_ready(lows);
    vectors++; if (lows !== 2) begin miscompares++; $display("FAIL b2b_wait_second: got %0d low cycles want 2", lows); end
    tick(); sample();
    vectors++; if ({o_we[sel], o_addr[sel], o_wben[sel], o_wdata[sel]} !== {1'b1, 8'h01, 4'hF, 32'hB0B0B0B0}) begin
      miscompares++; $display("FAIL b2b_commit_second: got we=%b addr=%h wben=%h wdata=%h want 1/01/f/b0b0b0b0",
                              o_we[sel], o_addr[sel], o_wben[sel], o_wdata[sel]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int lows;
    sel = 2;
    preload(2, 32, 32'h5A5A5A5A);
    tick(); drive_addr(1'b1, 32'h80, 3'd2); sample();
    tick(); hwdata = 32'hDEADBEEF; drive_addr(1'b0, 32'h100, 3'd2); sample();
    wait_ready(lows);
    vectors++; if (lows !== 3) begin miscompares++; $display("FAIL rmw_write_wait: got %0d low cycles want 3", lows); end
    tick(); drive_idle(); sample();
    vectors++; if ({o_ready[sel], o_cs[sel]} !== 2'b00) begin miscompares++; $display("FAIL rmw_read_wait_hold: got ready/cs=%b want 00", {o_ready[sel], o_cs[sel]}); end
    #1 rst = 1'b1;
    #1;
    vectors++; if ({o_ready[sel], o_resp[sel], o_cs[sel]} !== 3'b100) begin
      miscompares++; $display("FAIL rmw_async_reset: got ready/resp/cs=%b want 100", {o_ready[sel], o_resp[sel], o_cs[sel]});
    end
    tick(); rst = 1'b0;
    tick(); drive_addr(1'b0, 32'h80, 3'd2); sample();
    vectors++; if ({o_cs[sel], o_we[sel], o_addr[sel]} !== {2'b10, 8'h20}) begin
      miscompares++; $display("FAIL rmw_reread_issue: got cs=%b we=%b addr=%h want 1/0/20", o_cs[sel], o_we[sel], o_addr[sel]);
    end
    tick(); drive_idle(); sample();
    wait_ready(lows);
    vectors++; if (lows !== 3) begin miscompares++; $display("FAIL rmw_read_wait: got %0d low cycles want 3", lows); end
    vectors++; if (o_rdata[sel] !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL rmw_buffer_lost: got %h want 5a5a5a5a", o_rdata[sel]); end
  endtask

  task automatic test_align();
    sel = 0;
    tick(); drive_addr(1'b0, 32'h42, 3'd2); sample();
`ifdef AHB_SRAM_ALIGN_CHK_EN
    vectors++; if (o_cs[sel] !== 1'b0) begin miscompares++; $display("FAIL align_no_access: got cs=%b want 0", o_cs[sel]); end
    tick(); drive_idle(); sample();
    vectors++; if ({o_ready[sel], o_resp[sel], o_cs[sel]} !== 3'b010) begin
      miscompares++; $display("FAIL align_err1: got ready/resp/cs=%b want 010", {o_ready[sel], o_resp[sel], o_cs[sel]});
    end
    tick(); sample();
    vectors++; if ({o_ready[sel], o_resp[sel]} !== 2'b11) begin miscompares++; $display("FAIL align_err2: got ready/resp=%b want 11", {o_ready[sel], o_resp[sel]}); end
    tick(); sample();
    vectors++; if ({o_ready[sel], o_resp[sel]} !== 2'b10) begin miscompares++; $display("FAIL align_after_err: got ready/resp=%b want 10", {o_ready[sel], o_resp[sel]}); end
`else
    vectors++; if ({o_cs[sel], o_addr[sel]} !== {1'b1, 8'h10}) begin
      miscompares++; $display("FAIL align_read_issue: got cs=%b addr=%h want 1/10", o_cs[sel], o_addr[sel]);
    end
    tick(); drive_idle(); sample();
    vectors++; if ({o_ready[sel], o_resp[sel]} !== 2'b10) begin miscompares++; $display("FAIL align_okay: got ready/resp=%b want 10", {o_ready[sel], o_resp[sel]}); end
    vectors++; if (o_rdata[sel] !== 32'hAA223344) begin miscompares++; $display("FAIL align_data: got %h want aa223344", o_rdata[sel]); end
`endif
  endtask

  task automatic test_commit_on_idle();
    sel = 0;
    tick(); drive_addr(1'b1, 32'h20, 3'd2); sample();
    tick(); hwdata = 32'hCAFEF00D; drive_addr(1'b0, 32'h24, 3'd2); sample();
    vectors++; if ({o_cs[sel], o_we[sel], o_addr[sel]} !== {2'b10, 8'h09}) begin
      miscompares++; $display("FAIL idle_read1: got cs=%b we=%b addr=%h want 1/0/09", o_cs[sel], o_we[sel], o_addr[sel]);
    end
    tick(); sample();
    vectors++; if ({o_cs[sel], o_we[sel]} !== 2'b10) begin miscompares++; $display("FAIL idle_read_priority: got cs/we=%b want 10", {o_cs[sel], o_we[sel]}); end
    vectors++; if (o_rdata[sel] !== 32'd0) begin miscompares++; $display("FAIL idle_no_false_merge: got %h want 0", o_rdata[sel]); end
    tick(); drive_idle(); sample();
    vectors++; if ({o_we[sel], o_addr[sel], o_wdata[sel]} !== {1'b1, 8'h08, 32'hCAFEF00D}) begin
      miscompares++; $display("FAIL idle_commit: got we=%b addr=%h wdata=%h want 1/08/cafef00d", o_we[sel], o_addr[sel], o_wdata[sel]);
    end
    tick(); drive_addr(1'b0, 32'h20, 3'd2); sample();
    vectors++; if ({o_cs[sel], o_we[sel], o_addr[sel]} !== {2'b10, 8'h08}) begin
      miscompares++; $display("FAIL idle_direct_read: got cs=%b we=%b addr=%h want 1/0/08", o_cs[sel], o_we[sel], o_addr[sel]);
    end
    tick(); drive_idle(); sample();
    vectors++; if (o_rdata[sel] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL idle_sram_data: got %h want cafef00d", o_rdata[sel]); end
  endtask

  initial begin
    pl_en  = 1'b0;
    pl_dut = 0;
    pl_addr = '0;
    pl_data = 32'd0;
    hwdata = 32'd0;
    sel    = 0;
    drive_idle();
    test_reset();
    test_write_read_merge();
    test_byte_merge();
    test_back_to_back();
    test_reset_mid_wait();
    test_align();
    test_commit_on_idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
